pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_fetch_unit: five-state PC sequencer with stall, redirect and trap.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStall,
  input  logic             iPCSrc,
  input  logic             iTargetSel,
  input  logic [31:0]      iImmExt,
  input  logic [31:0]      iJumpReg,
  output logic [31:0]      oPC,
  output logic [31:0]      oPCPlus4,
  output logic             oValid,
  output logic             oRedirect,
  output logic             oMisaligned,
  output logic [CNT_W-1:0] oRedirectCount
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_HOLD   = 3'd2,
    S_BUBBLE = 3'd3,
    S_TRAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_valid;
  logic             r_redirect;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target;
  logic             w_aligned;
  logic             w_cnt_sat;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Register jumps drop bit 0 so JALR-style targets are halfword-agnostic.
  assign w_target   = iTargetSel ? (iJumpReg & ~32'h1) : (r_pc + iImmExt);
  assign w_aligned  = (w_target[1:0] == 2'b00);
  assign w_cnt_sat  = &r_count;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_VECTOR;
      r_valid      <= 1'b0;
      r_redirect   <= 1'b0;
      r_misaligned <= 1'b0;
      r_count      <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
        end
        S_RUN: begin
          if (iStall) begin
            r_state <= S_HOLD;
            r_valid <= 1'b0;
          end else if (iPCSrc) begin
            r_valid <= 1'b0;
            if (w_aligned) begin
              r_pc       <= w_target;
              r_redirect <= 1'b1;
              r_state    <= S_BUBBLE;
              if (!w_cnt_sat) r_count <= r_count + c_cnt_one;
            end else begin
              r_misaligned <= 1'b1;
              r_state      <= S_TRAP;
            end
          end else begin
            r_pc    <= w_pc_plus4;
            r_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          // PC is not advanced on exit so the held instruction re-issues.
          if (!iStall) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_BUBBLE: begin
          r_state <= iStall ? S_HOLD : S_RUN;
          r_valid <= !iStall;
        end
        S_TRAP: begin
          r_valid      <= 1'b0;
          r_misaligned <= 1'b1;
        end
        default: begin
          r_state <= S_BOOT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oPC            = r_pc;
  assign oPCPlus4       = w_pc_plus4;
  assign oValid         = r_valid;
  assign oRedirect      = r_redirect;
  assign oMisaligned    = r_misaligned;
  assign oRedirectCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pc_fetch_unit: directed checks of sequencing, redirect, stall, trap.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_pc_fetch_unit;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iStall;
  logic        iPCSrc;
  logic        iTargetSel;
  logic [31:0] iImmExt;
  logic [31:0] iJumpReg;

  logic [31:0] pc0, pc1, pc2, p4_0, p4_1, p4_2;
  logic        v0, v1, v2, rd0, rd1, rd2, ms0, ms1, ms2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 iClk = ~iClk;

  pc_fetch_unit u_dut0 (
    .iClk(iClk), .iRstN(iRstN), .iStall(iStall), .iPCSrc(iPCSrc),
    .iTargetSel(iTargetSel), .iImmExt(iImmExt), .iJumpReg(iJumpReg),
    .oPC(pc0), .oPCPlus4(p4_0), .oValid(v0), .oRedirect(rd0),
    .oMisaligned(ms0), .oRedirectCount(cnt0)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut1 (
    .iClk(iClk), .iRstN(iRstN), .iStall(iStall), .iPCSrc(iPCSrc),
    .iTargetSel(iTargetSel), .iImmExt(iImmExt), .iJumpReg(iJumpReg),
    .oPC(pc1), .oPCPlus4(p4_1), .oValid(v1), .oRedirect(rd1),
    .oMisaligned(ms1), .oRedirectCount(cnt1)
  );

  pc_fetch_unit #(.CNT_W(2)) u_dut2 (
    .iClk(iClk), .iRstN(iRstN), .iStall(iStall), .iPCSrc(iPCSrc),
    .iTargetSel(iTargetSel), .iImmExt(iImmExt), .iJumpReg(iJumpReg),
    .oPC(pc2), .oPCPlus4(p4_2), .oValid(v2), .oRedirect(rd2),
    .oMisaligned(ms2), .oRedirectCount(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Checks the main instance's PC/valid/redirect in one call.
  task automatic chk3(input string tag, input logic [31:0] epc, input logic ev, input logic erd);
    chk({tag, ".pc"}, pc0, epc);
    chk({tag, ".valid"}, {31'd0, v0}, {31'd0, ev});
    chk({tag, ".redirect"}, {31'd0, rd0}, {31'd0, erd});
  endtask

  initial begin
    iRstN = 1'b0; iStall = 1'b0; iPCSrc = 1'b0; iTargetSel = 1'b0;
    iImmExt = 32'd0; iJumpReg = 32'd0;
    step(); step();
    chk3("rst0", 32'h0, 1'b0, 1'b0);
    chk("rst0.mis", {31'd0, ms0}, 32'd0);
    chk("rst0.cnt", {16'd0, cnt0}, 32'd0);
    chk("rst1.pc", pc1, 32'hFFFF_FFF8);

    // Sequential run from both reset vectors
    iRstN = 1'b1;
    #1;
    chk3("boot", 32'h0, 1'b0, 1'b0);
    chk("boot1.valid", {31'd0, v1}, 32'd0);
    step(); chk3("seq0", 32'h0, 1'b1, 1'b0);
    chk("seq0.w", pc1, 32'hFFFF_FFF8);
    chk("seq0.w.valid", {31'd0, v1}, 32'd1);
    step(); chk3("seq4", 32'h4, 1'b1, 1'b0);
    chk("seq4.p4", p4_0, 32'h8);
    chk("seqw.pc", pc1, 32'hFFFF_FFFC);
    chk("seqw.p4", p4_1, 32'h0);
    step(); chk3("seq8", 32'h8, 1'b1, 1'b0);
    chk("seqw.wrap", pc1, 32'h0);
    chk("seqw.mis", {31'd0, ms1}, 32'd0);
    step(); chk3("seq12", 32'hC, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    iRstN = 1'b0;
    #1;
    chk3("arst", 32'h0, 1'b0, 1'b0);
    step();
    iRstN = 1'b1;
    step(); step(); step();
    chk3("run8", 32'h8, 1'b1, 1'b0);

    // PC-relative branch back to 0 (redirect 1)
    iPCSrc = 1'b1; iTargetSel = 1'b0; iImmExt = 32'hFFFF_FFF8;
    step(); chk3("br.bub", 32'h0, 1'b0, 1'b1);
    chk("br.cnt", {16'd0, cnt0}, 32'd1);
    iPCSrc = 1'b0;
    step(); chk3("br.run", 32'h0, 1'b1, 1'b0);
    step(); step(); step(); step();
    chk3("run10", 32'h10, 1'b1, 1'b0);

    // Register jump with bit 0 cleared (redirect 2)
    iPCSrc = 1'b1; iTargetSel = 1'b1; iJumpReg = 32'h101;
    step(); chk3("jr.bub", 32'h100, 1'b0, 1'b1);
    iPCSrc = 1'b0;
    step(); chk3("jr.run", 32'h100, 1'b1, 1'b0);
    chk("jr.cnt", {16'd0, cnt0}, 32'd2);

    // Jump to 0x20 (redirect 3), then stall with a pending redirect
    iPCSrc = 1'b1; iTargetSel = 1'b1; iJumpReg = 32'h20;
    step(); chk3("j20.bub", 32'h20, 1'b0, 1'b1);
    iPCSrc = 1'b0;
    step(); chk3("j20.run", 32'h20, 1'b1, 1'b0);
    iStall = 1'b1; iPCSrc = 1'b1; iTargetSel = 1'b0; iImmExt = 32'h40;
    step(); chk3("stall1", 32'h20, 1'b0, 1'b0);
    step(); chk3("stall2", 32'h20, 1'b0, 1'b0);
    step(); chk3("stall3", 32'h20, 1'b0, 1'b0);
    chk("stall.cnt", {16'd0, cnt0}, 32'd3);
    iStall = 1'b0; iPCSrc = 1'b0;
    step(); chk3("unstall", 32'h20, 1'b1, 1'b0);
    step(); chk3("unstall+4", 32'h24, 1'b1, 1'b0);

    // Redirect 4 to 0x40, stall in the bubble with iPCSrc ignored
    iPCSrc = 1'b1; iTargetSel = 1'b0; iImmExt = 32'h1C;
    step(); chk3("b40.bub", 32'h40, 1'b0, 1'b1);
    iStall = 1'b1; iImmExt = 32'h100;
    step(); chk3("b40.hold", 32'h40, 1'b0, 1'b0);
    iStall = 1'b0; iPCSrc = 1'b0;
    step(); chk3("b40.run", 32'h40, 1'b1, 1'b0);
    chk("b40.cnt", {16'd0, cnt0}, 32'd4);

    // Redirect 5 onto itself; the 2-bit counter saturates at 3
    iPCSrc = 1'b1; iImmExt = 32'h0;
    step(); chk3("self.bub", 32'h40, 1'b0, 1'b1);
    iPCSrc = 1'b0;
    step(); chk3("self.run", 32'h40, 1'b1, 1'b0);
    chk("sat.cnt16", {16'd0, cnt0}, 32'd5);
    chk("sat.cnt2", {30'd0, cnt2}, 32'd3);

    // Misaligned target traps and absorbs all inputs
    iPCSrc = 1'b1; iImmExt = 32'h6;
    step(); chk3("trap", 32'h40, 1'b0, 1'b0);
    chk("trap.mis", {31'd0, ms0}, 32'd1);
    chk("trap.cnt", {16'd0, cnt0}, 32'd5);
    iImmExt = 32'h0; iStall = 1'b0;
    step(); step(); step();
    chk3("trap.abs", 32'h40, 1'b0, 1'b0);
    chk("trap.abs.mis", {31'd0, ms0}, 32'd1);
    chk("trap.abs.cnt2", {30'd0, cnt2}, 32'd3);
    iRstN = 1'b0;
    #1;
    chk3("trap.rst", 32'h0, 1'b0, 1'b0);
    chk("trap.rst.mis", {31'd0, ms0}, 32'd0);
    chk("trap.rst.cnt", {16'd0, cnt0}, 32'd0);
    iPCSrc = 1'b0;
    step();
    iRstN = 1'b1;
    step(); chk3("post.run", 32'h0, 1'b1, 1'b0);

    // Reset inside BUBBLE discards the redirect target
    iPCSrc = 1'b1; iImmExt = 32'h80;
    step(); chk3("rb.bub", 32'h80, 1'b0, 1'b1);
    iPCSrc = 1'b0;
    iRstN = 1'b0;
    #1;
    chk3("rb.rst", 32'h0, 1'b0, 1'b0);
    step();
    iRstN = 1'b1;
    #1;
    chk3("rb.boot", 32'h0, 1'b0, 1'b0);
    step(); chk3("rb.run", 32'h0, 1'b1, 1'b0);
    step(); chk3("rb.run4", 32'h4, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
